// File: rtl/ascii_hex_pkg.sv
// Shared constants for the ASCII hex word parser: terminator codes,
// character classes and parser state encodings.
package ascii_hex_pkg;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  typedef enum logic [1:0] {
    CLS_DIGIT = 2'd0,
    CLS_TERM  = 2'd1,
    CLS_X     = 2'd2,
    CLS_INV   = 2'd3
  } char_cls_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  function automatic logic is_term(input logic [7:0] ch);
    return (ch == CH_LF) || (ch == CH_CR) || (ch == CH_SP) || (ch == CH_COMMA);
  endfunction

endpackage

// File: rtl/ascii_hex_word_parser_char_class.sv
// Combinational ASCII classifier: maps one byte to a character class and,
// for hex digits, its 4-bit value.
module hex_char_class
  import ascii_hex_pkg::*;
#(
  parameter int LOWER_EN  = 1,
  parameter int PREFIX_EN = 1
) (
  input  logic [7:0] data,
  output char_cls_t  cls,
  output logic [3:0] nibble
);

  always_comb begin
    cls    = CLS_INV;
    nibble = 4'd0;
    if (data >= 8'h30 && data <= 8'h39) begin
      cls    = CLS_DIGIT;
      nibble = data[3:0];
    end else if (data >= 8'h41 && data <= 8'h46) begin
      // 'A'..'F' and 'a'..'f' both carry 1..6 in the low nibble
      cls    = CLS_DIGIT;
      nibble = data[3:0] + 4'd9;
    end else if (LOWER_EN != 0 && data >= 8'h61 && data <= 8'h66) begin
      cls    = CLS_DIGIT;
      nibble = data[3:0] + 4'd9;
    end else if (is_term(data)) begin
      cls = CLS_TERM;
    end else if (PREFIX_EN != 0 && (data == 8'h78 || data == 8'h58)) begin
      cls = CLS_X;
    end
  end

endmodule

// File: rtl/ascii_hex_word_parser.sv
// Streaming ASCII hex token parser: accumulates hex digits into a right-aligned
// word and emits it, with an error flag, when a terminator arrives.
module ascii_hex_word_parser
  import ascii_hex_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int LOWER_EN  = 1,
  parameter int PREFIX_EN = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic [4*DIGITS-1:0]          word,
  output logic                         word_err,
  output logic [$clog2(DIGITS+1)-1:0]  word_digits,
  output logic                         word_valid,
  input  logic                         word_ready
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

  char_cls_t      cls;
  logic [3:0]     nibble;
  logic [1:0]     state;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_next;
  logic [CW-1:0]  cnt;
  logic           prefix_seen;
  logic           prefix_ok;
  logic           take;

  hex_char_class #(
    .LOWER_EN  (LOWER_EN),
    .PREFIX_EN (PREFIX_EN)
  ) u_class (
    .data   (rx_data),
    .cls    (cls),
    .nibble (nibble)
  );

  assign rx_ready = ~word_valid;
  assign take     = rx_valid && rx_ready;
  assign acc_next = (acc << 4) | W'(nibble);
  // A lone leading '0' is the only digit history that may turn into "0x"
  assign prefix_ok = (cnt == CW'(1)) && (acc == '0) && !prefix_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      acc         <= '0;
      cnt         <= '0;
      prefix_seen <= 1'b0;
      word        <= '0;
      word_err    <= 1'b0;
      word_digits <= '0;
      word_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            if (cls == CLS_DIGIT) begin
              acc   <= W'(nibble);
              cnt   <= CW'(1);
              state <= ST_ACCUM;
            end else if (cls != CLS_TERM) begin
              state <= ST_DISCARD;
            end
          end
        end
        ST_ACCUM: begin
          if (take) begin
            case (cls)
              CLS_DIGIT: begin
                if (cnt == CNT_MAX) begin
                  state <= ST_DISCARD;
                end else begin
                  acc <= acc_next;
                  cnt <= cnt + CW'(1);
                end
              end
              CLS_X: begin
                if (prefix_ok) begin
                  acc         <= '0;
                  cnt         <= '0;
                  prefix_seen <= 1'b1;
                end else begin
                  state <= ST_DISCARD;
                end
              end
              CLS_TERM: begin
                // cnt==0 here means a bare prefix; acc is already zero then
                word        <= acc;
                word_err    <= (cnt == '0);
                word_digits <= cnt;
                word_valid  <= 1'b1;
                state       <= ST_HOLD;
              end
              default: state <= ST_DISCARD;
            endcase
          end
        end
        ST_DISCARD: begin
          if (take && cls == CLS_TERM) begin
            word        <= '0;
            word_err    <= 1'b1;
            word_digits <= '0;
            word_valid  <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        default: begin
          if (word_ready) begin
            word_valid  <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            prefix_seen <= 1'b0;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ascii_hex_word_parser.md
Name: ascii_hex_word_parser

Overview:
- Streaming ASCII-to-binary parser. It takes a byte stream with a valid/ready handshake and accumulates hex digits (0-9, A-F, optionally a-f) into a right-aligned word of 4*DIGITS bits.
- On a terminator character it emits one word with a per-word error flag.
- Sits between the UART RX byte path and the command/register decode logic. It is the sequential, multi-digit successor to the single-character ASCII-to-hex decoder.

Parameters:
- DIGITS, 8: maximum hex digits per token; WORD width = 4*DIGITS.
- LOWER_EN, 1: 1 accepts a-f as digits; 0 treats 0x61-0x66 as invalid.
- PREFIX_EN, 1: 1 accepts one optional "0x"/"0X" prefix per token; 0 treats x/X as invalid.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RX_DATA  in  8  ASCII byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  parser accepts byte this cycle; equals ~WORD_VALID.
- WORD  out  4*DIGITS  parsed value, zero-extended in the upper digits.
- WORD_ERR  out  1  token contained an invalid char or overflowed; WORD=0 when set.
- WORD_DIGITS  out  $clog2(DIGITS+1)  number of digits in the token (excluding prefix).
- WORD_VALID  out  1  output word pending.
- WORD_READY  in  1  consumer accepts word.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous, active-low (RST_N).
- Reset values: RX_READY=1; WORD=0, WORD_ERR=0, WORD_DIGITS=0, WORD_VALID=0; state=IDLE; accumulator, count and prefix flag all 0.
- Byte accepted: when RX_VALID && RX_READY at a rising edge.
- Character classes:
  - DIGIT: 0x30-0x39, 0x41-0x46, and 0x61-0x66 if LOWER_EN.
  - TERM: 0x0A, 0x0D, 0x20, 0x2C.
  - XCHAR: 0x78/0x58 if PREFIX_EN.
  - INVALID: everything else.
- States:
  - IDLE (no digits yet):
    - DIGIT: acc=nibble, cnt=1 -> ACCUM.
    - TERM: ignored (empty token, no output), stay.
    - XCHAR or INVALID: -> DISCARD.
  - ACCUM:
    - DIGIT with cnt<DIGITS: acc=(acc<<4)|nibble, cnt+1.
    - DIGIT with cnt==DIGITS: overflow -> DISCARD.
    - XCHAR when cnt==1, acc==0, first digit was '0' and prefix not yet seen: acc=0, cnt=0, prefix_seen=1, stay in ACCUM.
    - Any other XCHAR, or INVALID: -> DISCARD.
    - TERM with cnt>=1: load WORD=acc, WORD_DIGITS=cnt, WORD_ERR=0, WORD_VALID=1 -> HOLD.
    - TERM with cnt==0 (bare "0x" prefix): WORD=0, WORD_DIGITS=0, WORD_ERR=1, WORD_VALID=1 -> HOLD.
  - DISCARD: swallow all non-TERM bytes. TERM: WORD=0, WORD_DIGITS=0, WORD_ERR=1, WORD_VALID=1 -> HOLD.
  - HOLD: RX_READY=0. On WORD_VALID && WORD_READY: WORD_VALID=0, accumulator, count and prefix flag cleared -> IDLE. WORD/WORD_ERR/WORD_DIGITS are held stable until then.
- Latency: terminator accepted at edge N -> WORD_VALID=1 after edge N; earliest next byte accepted at edge N+2 when WORD_READY=1 at edge N+1. Throughput is one byte per cycle inside a token.
- Outputs are registered; no combinational path from RX_DATA to WORD*.
- WORD_READY while WORD_VALID=0: no effect.
- RX_VALID held while RX_READY=0: byte not consumed, no state change.
- RST_N low at any time, including mid-token or during HOLD: immediate return to reset values; the partial token is lost and no word is emitted.

Decomposition:
- Package ascii_hex_pkg:
  - Terminator constants CH_LF, CH_CR, CH_SP, CH_COMMA.
  - Class encoding: CLS_DIGIT, CLS_TERM, CLS_X, CLS_INV.
  - State encoding: ST_IDLE, ST_ACCUM, ST_DISCARD, ST_HOLD.
- Sub-module hex_char_class: combinational, parametrised by LOWER_EN/PREFIX_EN; RX_DATA -> class + 4-bit nibble. The parser FSM, accumulator and output register stay in the top.

Test Plan:
- DIGITS=8: "1A2b\n", WORD_READY=1 -> one word WORD=0x00001A2B, WORD_DIGITS=4, WORD_ERR=0; RX_READY low exactly one cycle.
- "0xFF " then "0X7," -> WORD=0x000000FF/DIGITS=2, then 0x00000007/DIGITS=1, both ERR=0. "0x\n" -> ERR=1, WORD=0. With PREFIX_EN=0, "0xFF " -> ERR=1.
- "123456789\r" (9 digits, DIGITS=8) -> WORD=0, ERR=1, DIGITS=0. "12345678\r" -> WORD=0x12345678, ERR=0, DIGITS=8.
- "1G3 " -> ERR=1, WORD=0. With LOWER_EN=0, "ab " -> ERR=1. Leading "  \n," empty tokens -> no WORD_VALID.
- Backpressure: "5 6 " streamed with WORD_READY=0 for 10 cycles -> WORD=0x5 held stable, RX_READY=0, '6' not consumed; after READY -> second word 0x6.
- Assert RST_N=0 after "AB" mid-token and again during HOLD -> all outputs at reset values asynchronously. Then "C\n" -> WORD=0xC (no residue).
